// File: rtl/mem_router.sv
// Single-master to NUM_SLAVES address router with one-hot slave select,
// per-transaction timeout and a saturating error counter.
module mem_router #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SLAVES     = 5,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic                             m_we,
    input  logic [3:0]                       m_be,
    input  logic                             m_req,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_ack,
    output logic                             m_err,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic                             s_we,
    output logic [3:0]                       s_be,
    output logic [NUM_SLAVES-1:0]            s_req,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ack,
    output logic [7:0]                       err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   s_addr_q,  s_addr_d;
    logic [DATA_WIDTH-1:0]   s_wdata_q, s_wdata_d;
    logic                    s_we_q,    s_we_d;
    logic [3:0]              s_be_q,    s_be_d;
    logic [NUM_SLAVES-1:0]   s_req_q,   s_req_d;
    logic [DATA_WIDTH-1:0]   m_rdata_q, m_rdata_d;
    logic                    m_err_q,   m_err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;

    logic [NUM_SLAVES-1:0]   match_oh;
    logic                    match_hit;
    logic                    ack_hit;
    logic [DATA_WIDTH-1:0]   rdata_sel;
    logic [7:0]              err_cnt_inc;

    // Address decode: the first (lowest-index) matching window wins.
    always_comb begin
        match_oh  = '0;
        match_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!match_hit &&
                ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                match_oh[i] = 1'b1;
                match_hit   = 1'b1;
            end
        end
    end

    // The one-hot s_req_q doubles as the select, so acks and read data from
    // unselected slaves are masked out here.
    always_comb begin
        ack_hit   = |(s_ack & s_req_q);
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_req_q[i]) begin
                rdata_sel = rdata_sel | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_we_d    = s_we_q;
        s_be_d    = s_be_q;
        s_req_d   = s_req_q;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        err_cnt_d = err_cnt_q;
        tmo_cnt_d = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (m_req) begin
                    if (match_hit) begin
                        s_addr_d  = m_addr;
                        s_wdata_d = m_wdata;
                        s_we_d    = m_we;
                        s_be_d    = m_be;
                        s_req_d   = match_oh;
                        tmo_cnt_d = '0;
                        state_d   = WAIT;
                    end else begin
                        m_rdata_d = '0;
                        m_err_d   = 1'b1;
                        err_cnt_d = err_cnt_inc;
                        state_d   = DONE;
                    end
                end
            end

            WAIT: begin
                if (ack_hit) begin
                    s_req_d   = '0;
                    m_rdata_d = rdata_sel;
                    m_err_d   = 1'b0;
                    state_d   = DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    s_req_d   = '0;
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    err_cnt_d = err_cnt_inc;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            DONE: begin
                m_err_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                s_req_d = '0;
                m_err_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_we_q    <= 1'b0;
            s_be_q    <= '0;
            s_req_q   <= '0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
            err_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
            state_q   <= state_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_we_q    <= s_we_d;
            s_be_q    <= s_be_d;
            s_req_q   <= s_req_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
            err_cnt_q <= err_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign m_ack   = (state_q == DONE);
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_we    = s_we_q;
    assign s_be    = s_be_q;
    assign s_req   = s_req_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mem_router.sv
// Directed self-checking bench for mem_router: three slaves, 16-cycle timeout.
module tb_mem_router;

    logic        clk;
    logic        rst_n;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [3:0]  m_be;
    logic        m_req;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        m_err;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_we;
    logic [3:0]  s_be;
    logic [2:0]  s_req;
    logic [95:0] s_rdata;
    logic [2:0]  s_ack;
    logic [7:0]  err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave0 decodes 0x00xx_xxxx so that it does not shadow the slave2 window.
    mem_router #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .NUM_SLAVES     (3),
        .SLAVE_BASE     ({32'h0200_0000, 32'h8000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFFFF_0000, 32'hF000_0000, 32'hFF00_0000}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_req   (m_req),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_we    (s_we),
        .s_be    (s_be),
        .s_req   (s_req),
        .s_rdata (s_rdata),
        .s_ack   (s_ack),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [3:0] be);
        m_addr  = addr;
        m_wdata = wdata;
        m_we    = we;
        m_be    = be;
        m_req   = 1'b1;
    endtask

    int req_hi;
    int acks;

    initial begin
        rst_n   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_we    = 1'b0;
        m_be    = '0;
        m_req   = 1'b0;
        s_rdata = '0;
        s_ack   = '0;

        tick();
        tick();
        check("rst_s_req",   s_req,   3'b000);
        check("rst_m_ack",   m_ack,   1'b0);
        check("rst_m_err",   m_err,   1'b0);
        check("rst_m_rdata", m_rdata, 32'h0);
        check("rst_s_addr",  s_addr,  32'h0);
        check("rst_err_cnt", err_cnt, 8'd0);
        rst_n = 1'b1;
        tick();

        // Read from slave1, acked in the first WAIT cycle.
        request(32'h8000_0010, 32'h0, 1'b0, 4'hF);
        tick();
        check("rd_s_req",  s_req,  3'b010);
        check("rd_s_addr", s_addr, 32'h8000_0010);
        check("rd_s_we",   s_we,   1'b0);
        check("rd_ack_c1", m_ack,  1'b0);
        s_ack = 3'b010;
        s_rdata[32 +: 32] = 32'hCAFE_F00D;
        tick();
        check("rd_m_ack",   m_ack,   1'b1);
        check("rd_m_rdata", m_rdata, 32'hCAFE_F00D);
        check("rd_m_err",   m_err,   1'b0);
        check("rd_s_req_clr", s_req, 3'b000);
        m_req = 1'b0;
        s_ack = 3'b000;
        tick();
        check("rd_ack_pulse", m_ack,   1'b0);
        check("rd_rdata_hold", m_rdata, 32'hCAFE_F00D);

        // Write to slave2, acked after three WAIT cycles.
        request(32'h0200_4000, 32'h1234_5678, 1'b1, 4'b1111);
        tick();
        check("wr_s_req",   s_req,   3'b100);
        check("wr_s_addr",  s_addr,  32'h0200_4000);
        check("wr_s_wdata", s_wdata, 32'h1234_5678);
        check("wr_s_we",    s_we,    1'b1);
        check("wr_s_be",    s_be,    4'b1111);
        tick();
        check("wr_wait_c2", m_ack, 1'b0);
        check("wr_hold_c2", s_req, 3'b100);
        tick();
        s_ack = 3'b100;
        s_rdata[64 +: 32] = 32'hDEAD_BEEF;
        tick();
        check("wr_m_ack",   m_ack,   1'b1);
        check("wr_m_err",   m_err,   1'b0);
        check("wr_m_rdata", m_rdata, 32'hDEAD_BEEF);
        m_req = 1'b0;
        s_ack = 3'b000;
        tick();

        // Decode error: no slave window covers 0x4000_0000.
        request(32'h4000_0000, 32'h0, 1'b0, 4'hF);
        tick();
        check("de_s_req",   s_req,   3'b000);
        check("de_m_ack",   m_ack,   1'b1);
        check("de_m_err",   m_err,   1'b1);
        check("de_m_rdata", m_rdata, 32'h0);
        check("de_err_cnt", err_cnt, 8'd1);
        m_req = 1'b0;
        tick();
        check("de_ack_drop", m_ack, 1'b0);
        check("de_err_drop", m_err, 1'b0);

        // Timeout: slave0 never acks.
        request(32'h0000_1000, 32'h0, 1'b0, 4'hF);
        tick();
        check("to_s_req", s_req, 3'b001);
        req_hi = 1;
        for (int i = 0; i < 40 && m_ack !== 1'b1; i++) begin
            tick();
            if (s_req[0] === 1'b1) req_hi++;
        end
        check("to_req_cycles", req_hi,  16);
        check("to_m_ack",      m_ack,   1'b1);
        check("to_m_err",      m_err,   1'b1);
        check("to_m_rdata",    m_rdata, 32'h0);
        check("to_err_cnt",    err_cnt, 8'd2);
        m_req = 1'b0;
        tick();
        s_ack = 3'b001;
        tick();
        s_ack = 3'b000;
        check("late_ack_m_ack", m_ack,   1'b0);
        check("late_ack_s_req", s_req,   3'b000);
        check("late_ack_errs",  err_cnt, 8'd2);
        tick();
        check("late_ack_idle", m_ack, 1'b0);

        // Ack from unselected slave2 while slave1 is selected.
        request(32'h8000_0020, 32'h0, 1'b0, 4'hF);
        tick();
        check("xa_s_req", s_req, 3'b010);
        s_ack = 3'b100;
        s_rdata[64 +: 32] = 32'h1111_1111;
        tick();
        check("xa_ignored_c2", m_ack, 1'b0);
        check("xa_hold_c2",    s_req, 3'b010);
        tick();
        check("xa_ignored_c3", m_ack, 1'b0);
        s_ack = 3'b010;
        s_rdata[32 +: 32] = 32'h5A5A_0001;
        tick();
        check("xa_m_ack",   m_ack,   1'b1);
        check("xa_m_rdata", m_rdata, 32'h5A5A_0001);
        check("xa_m_err",   m_err,   1'b0);
        m_req = 1'b0;
        s_ack = 3'b000;
        tick();

        // 300 decode errors on top of the 2 already counted: saturates at 255.
        for (int j = 1; j <= 300; j++) begin
            request(32'h4000_0000, 32'h0, 1'b0, 4'hF);
            tick();
            m_req = 1'b0;
            tick();
            if (j == 252) check("sat_254", err_cnt, 8'd254);
            if (j == 253) check("sat_255", err_cnt, 8'd255);
        end
        check("sat_final", err_cnt, 8'd255);

        // Asynchronous reset in the middle of WAIT.
        request(32'h8000_0030, 32'h0, 1'b0, 4'hF);
        tick();
        check("rw_s_req", s_req, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_s_req_async", s_req,   3'b000);
        check("rw_m_ack_async", m_ack,   1'b0);
        check("rw_err_cnt",     err_cnt, 8'd0);
        m_req = 1'b0;
        tick();
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_ack === 1'b1) acks++;
        end
        check("rw_no_ack", acks, 0);
        request(32'h0200_0008, 32'hAAAA_5555, 1'b1, 4'b0011);
        tick();
        check("rw_next_s_req",   s_req,   3'b100);
        check("rw_next_s_wdata", s_wdata, 32'hAAAA_5555);
        check("rw_next_s_be",    s_be,    4'b0011);
        s_ack = 3'b100;
        s_rdata[64 +: 32] = 32'h0000_00A5;
        tick();
        check("rw_next_m_ack",   m_ack,   1'b1);
        check("rw_next_m_err",   m_err,   1'b0);
        check("rw_next_m_rdata", m_rdata, 32'h0000_00A5);
        m_req = 1'b0;
        s_ack = 3'b000;
        tick();
        check("rw_next_drop", m_ack, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
